// File: rtl/bcd_seq_converter_if.sv
// rtl/bcd_seq_converter_if.sv - handshake bundle for bcd_seq_converter; seg_out present only with BCD_SEG_EN
interface bcd_seq_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
`ifdef BCD_SEG_EN
  logic [7*DIGITS-1:0]   seg_out;
`endif

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, overflow
`ifdef BCD_SEG_EN
    , input seg_out
`endif
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, overflow
`ifdef BCD_SEG_EN
    , output seg_out
`endif
  );
endinterface

// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential double-dabble binary-to-BCD converter with valid/ready handshake
// Optional 7-segment encoder with leading-zero blanking enabled by BCD_SEG_EN.
module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic               clk,
  input logic               rst,
  bcd_seq_converter_if.slave bus
);
  localparam int FULL_DIGITS = (WIDTH * 3) / 10 + 1;
  localparam int EXT_DIGITS  = (DIGITS > FULL_DIGITS) ? DIGITS : FULL_DIGITS;
  localparam int CW          = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                    state, state_next;
  logic [4*FULL_DIGITS-1:0]  bcd_reg, bcd_adj, bcd_next;
  logic [WIDTH-1:0]          bin_reg, bin_next;
  logic [CW-1:0]             cnt;
  logic [4*EXT_DIGITS-1:0]   bcd_ext;
  logic [4*DIGITS-1:0]       bcd_q;
  logic                      ovf_q, ovf_next;
  logic                      accept, last_step;

  assign accept    = bus.in_valid && (state == IDLE);
  assign last_step = (state == SHIFT) && (cnt == CW'(1));

  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < FULL_DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
    end
    {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
  end

  // Widen to at least DIGITS so narrow widths still present DIGITS zero-padded digits.
  always_comb begin
    bcd_ext = '0;
    bcd_ext[4*FULL_DIGITS-1:0] = bcd_next;
  end

  generate
    if (FULL_DIGITS > DIGITS) begin : g_ovf
      assign ovf_next = |bcd_ext[4*FULL_DIGITS-1:4*DIGITS];
    end else begin : g_no_ovf
      assign ovf_next = 1'b0;
    end
  endgenerate

`ifdef BCD_SEG_EN
  logic [7*DIGITS-1:0] seg_q, seg_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Scan from the top digit; everything from the first nonzero digit down is lit.
  always_comb begin
    logic       lit;
    logic [3:0] digit;
    lit      = 1'b0;
    digit    = 4'd0;
    seg_next = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit = bcd_ext[4*i +: 4];
      if (digit != 4'd0 || i == 0)
        lit = 1'b1;
      if (lit)
        seg_next[7*i +: 7] = seg7(digit);
    end
  end

  assign bus.seg_out = seg_q;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)        state_next = SHIFT;
      SHIFT:   if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef BCD_SEG_EN
      seg_q   <= '0;
`endif
    end else if (accept) begin
      bin_reg <= bus.bin_in;
      bcd_reg <= '0;
      cnt     <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      bcd_reg <= bcd_next;
      bin_reg <= bin_next;
      cnt     <= cnt - CW'(1);
      if (last_step) begin
        bcd_q <= bcd_ext[4*DIGITS-1:0];
        ovf_q <= ovf_next;
`ifdef BCD_SEG_EN
        seg_q <= seg_next;
`endif
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.bcd_out   = bcd_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - randomized self-checking bench for bcd_seq_converter (seg checks with BCD_SEG_EN)
module tb_bcd_seq_converter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_seq_converter_if #(.WIDTH(8),  .DIGITS(3)) a_if ();
  bcd_seq_converter_if #(.WIDTH(8),  .DIGITS(2)) b_if ();
  bcd_seq_converter_if #(.WIDTH(16), .DIGITS(5)) c_if ();

  bcd_seq_converter #(.WIDTH(8),  .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  bcd_seq_converter #(.WIDTH(8),  .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  function automatic logic [63:0] to_bcd(input longint unsigned v, input int digits);
    logic [63:0]     r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [20:0] seg_model(input int v);
    logic [6:0]  tbl [10];
    logic [20:0] r;
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    r = '0;
    r[6:0] = tbl[v % 10];
    if (v >= 10)  r[13:7]  = tbl[(v / 10) % 10];
    if (v >= 100) r[20:14] = tbl[(v / 100) % 10];
    return r;
  endfunction

  task automatic convert_a(input int v, output logic [11:0] bcd, output logic ovf,
                           output logic [20:0] seg, output int lat);
    int w;
    w = 0;
    while (!a_if.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    a_if.in_valid = 1'b1;
    a_if.bin_in   = 8'(v);
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    lat = 0;
    while (!a_if.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    bcd = a_if.bcd_out;
    ovf = a_if.overflow;
    seg = '0;
`ifdef BCD_SEG_EN
    seg = a_if.seg_out;
`endif
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", a_if.in_ready); end
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", a_if.out_valid); end
    checks++; if (a_if.bcd_out !== 12'h000) begin errors++; $display("FAIL reset_bcd got=%h exp=000", a_if.bcd_out); end
    checks++; if (a_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", a_if.overflow); end
`ifdef BCD_SEG_EN
    checks++; if (a_if.seg_out !== 21'h0) begin errors++; $display("FAIL reset_seg got=%h exp=0", a_if.seg_out); end
`endif
  endtask

  task automatic test_directed();
    logic [11:0] bcd;
    logic        ovf;
    logic [20:0] seg;
    int          lat;
    convert_a(255, bcd, ovf, seg, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL max_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h255) begin errors++; $display("FAIL max_bcd got=%h exp=255", bcd); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL max_overflow got=%b exp=0", ovf); end
    convert_a(0, bcd, ovf, seg, lat);
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL zero_bcd got=%h exp=000", bcd); end
`ifdef BCD_SEG_EN
    checks++; if (seg !== {7'b0, 7'b0, 7'b1111110}) begin errors++; $display("FAIL zero_seg got=%b exp=%b", seg, {7'b0, 7'b0, 7'b1111110}); end
`endif
  endtask

  task automatic test_random();
    logic [11:0] bcd;
    logic [63:0] exp;
    logic        ovf;
    logic [20:0] seg;
    int          lat, v;
    repeat (16) begin
      v   = int'($urandom_range(0, 255));
      exp = to_bcd(longint'(v), 3);
      convert_a(v, bcd, ovf, seg, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL rand_latency v=%0d got=%0d exp=8", v, lat); end
      checks++; if (bcd !== exp[11:0]) begin errors++; $display("FAIL rand_bcd v=%0d got=%h exp=%h", v, bcd, exp[11:0]); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rand_overflow v=%0d got=%b exp=0", v, ovf); end
`ifdef BCD_SEG_EN
      checks++; if (seg !== seg_model(v)) begin errors++; $display("FAIL rand_seg v=%0d got=%b exp=%b", v, seg, seg_model(v)); end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] bcd;
    int          lat;
    a_if.in_valid = 1'b1;
    a_if.bin_in   = 8'd200;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    lat = 0;
    while (!a_if.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency got=%0d exp=8", lat); end
    a_if.in_valid = 1'b1;
    a_if.bin_in   = 8'd99;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (a_if.out_valid !== 1'b1 || a_if.in_ready !== 1'b0 || a_if.bcd_out !== 12'h200)
        begin errors++; $display("FAIL bp_hold cyc=%0d got v=%b r=%b bcd=%h exp v=1 r=0 bcd=200", i, a_if.out_valid, a_if.in_ready, a_if.bcd_out); end
    end
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_if.out_ready = 1'b0;
    checks++; if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0)
      begin errors++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", a_if.in_ready, a_if.out_valid); end
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    lat = 0;
    while (!a_if.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    bcd = a_if.bcd_out;
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_second_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h099) begin errors++; $display("FAIL bp_second_bcd got=%h exp=099", bcd); end
    a_if.out_ready = 1'b1;
    @(posedge clk); #1;
    a_if.out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [11:0] bcd;
    logic        ovf;
    logic [20:0] seg;
    int          lat;
    convert_a(123, bcd, ovf, seg, lat);
    a_if.in_valid = 1'b1;
    a_if.bin_in   = 8'd200;
    @(posedge clk); #1;
    a_if.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (a_if.in_ready !== 1'b1 || a_if.out_valid !== 1'b0 || a_if.bcd_out !== 12'h000)
      begin errors++; $display("FAIL mid_reset got r=%b v=%b bcd=%h exp r=1 v=0 bcd=000", a_if.in_ready, a_if.out_valid, a_if.bcd_out); end
    convert_a(42, bcd, ovf, seg, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL after_reset_latency got=%0d exp=8", lat); end
    checks++; if (bcd !== 12'h042) begin errors++; $display("FAIL after_reset_bcd got=%h exp=042", bcd); end
  endtask

  task automatic test_truncation();
    int          vals[$] = '{137, 99, 100, 255, 0};
    logic [63:0] exp;
    int          lat, w;
    repeat (6) vals.push_back(int'($urandom_range(0, 255)));
    foreach (vals[k]) begin
      exp = to_bcd(longint'(vals[k]), 2);
      w = 0;
      while (!b_if.in_ready && w < 50) begin @(posedge clk); #1; w++; end
      b_if.in_valid = 1'b1;
      b_if.bin_in   = 8'(vals[k]);
      @(posedge clk); #1;
      b_if.in_valid = 1'b0;
      lat = 0;
      while (!b_if.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      checks++; if (b_if.bcd_out !== exp[7:0]) begin errors++; $display("FAIL trunc_bcd v=%0d got=%h exp=%h", vals[k], b_if.bcd_out, exp[7:0]); end
      checks++; if (b_if.overflow !== (vals[k] >= 100)) begin errors++; $display("FAIL trunc_overflow v=%0d got=%b exp=%b", vals[k], b_if.overflow, vals[k] >= 100); end
      b_if.out_ready = 1'b1;
      @(posedge clk); #1;
      b_if.out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp [2];
    int          acc_t [2];
    int          n_acc, n_res;
    logic        pending;
    exp[0] = to_bcd(64'd65535, 5);
    exp[1] = to_bcd(64'd1, 5);
    acc_t[0] = 0;
    acc_t[1] = 0;
    n_acc = 0;
    n_res = 0;
    c_if.out_ready = 1'b1;
    c_if.in_valid  = 1'b1;
    c_if.bin_in    = 16'hFFFF;
    for (int t = 0; t < 80; t++) begin
      if (c_if.out_valid) begin
        if (n_res < 2) begin
          checks++; if (c_if.bcd_out !== exp[n_res][19:0] || c_if.overflow !== 1'b0)
            begin errors++; $display("FAIL b2b_result n=%0d got=%h ovf=%b exp=%h ovf=0", n_res, c_if.bcd_out, c_if.overflow, exp[n_res][19:0]); end
        end
        n_res++;
      end
      pending = c_if.in_valid && c_if.in_ready;
      if (pending && n_acc < 2) begin acc_t[n_acc] = t; n_acc++; end
      @(posedge clk); #1;
      if (pending) begin
        if (n_acc == 1) c_if.bin_in = 16'd1;
        else            c_if.in_valid = 1'b0;
      end
      if (n_res >= 2) break;
    end
    c_if.out_ready = 1'b0;
    c_if.in_valid  = 1'b0;
    checks++; if (n_res !== 2) begin errors++; $display("FAIL b2b_result_count got=%0d exp=2", n_res); end
    checks++; if (n_acc !== 2 || acc_t[1] - acc_t[0] !== 18)
      begin errors++; $display("FAIL b2b_accept_spacing got n=%0d gap=%0d exp n=2 gap=18", n_acc, acc_t[1] - acc_t[0]); end
  endtask

  initial begin
    a_if.in_valid = 1'b0; a_if.bin_in = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.bin_in = '0; b_if.out_ready = 1'b0;
    c_if.in_valid = 1'b0; c_if.bin_in = '0; c_if.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mid_reset();
    test_truncation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
